// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - registered execute-stage ALU with valid/ready handshakes
//
// Purpose: performs the ALUControl-selected operation on two WIDTH-bit operands
// and holds the result plus zero/overflow/illegal flags in a single output
// register that can stall under downstream backpressure.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  input handshake (in_ready = !out_valid || out_ready)
//   alu_ctrl             4-bit ALUControl code
//   op_a, op_b           WIDTH-bit operands
//   out_valid/out_ready  output handshake
//   result               registered WIDTH-bit result
//   zero                 registered result == 0
//   overflow             registered signed overflow (ADD/SUB only)
//   illegal              registered unsupported-code flag

module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q,   result_d;
    logic             zero_q,     zero_d;
    logic             overflow_q, overflow_d;
    logic             illegal_q,  illegal_d;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             slt_bit;
    logic             in_xfer;
    logic             out_xfer;

    assign in_ready = !out_valid_q || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;
    // Exact signed compare; the sign of diff would be wrong when the subtraction overflows.
    assign slt_bit = $signed(op_a) < $signed(op_b);

    always_comb begin
        result_d   = '0;
        overflow_d = 1'b0;
        illegal_d  = 1'b0;
        unique case (alu_ctrl)
            OP_AND: result_d = op_a & op_b;
            OP_OR:  result_d = op_a | op_b;
            OP_ADD: begin
                result_d   = sum;
                overflow_d = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                             (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                result_d   = diff;
                overflow_d = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                             (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SLT: result_d = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_NOR: result_d = ~(op_a | op_b);
            default: illegal_d = 1'b1;
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (in_xfer) begin
            // Covers the simultaneous consume-and-load case: valid stays high, no bubble.
            out_valid_q <= 1'b1;
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            illegal_q   <= illegal_d;
        end else if (out_xfer) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit

module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         illegal;

    int checks   = 0;
    int failures = 0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         v;
        logic         ill;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b,
                                logic [W-1:0] r, logic z, logic v, logic il);
        vec_t t;
        t.ctrl = c; t.a = a; t.b = b; t.res = r; t.z = z; t.v = v; t.ill = il;
        return t;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] bp_exp[4];
    logic [W-1:0] bp_a[4];
    logic [W-1:0] bp_b[4];
    logic         pattern[5];

    initial begin
        vecs[0]  = mk(4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0);
        vecs[1]  = mk(4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1, 0, 0);
        vecs[2]  = mk(4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 0);
        vecs[3]  = mk(4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0);
        vecs[4]  = mk(4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1, 0, 0);
        vecs[5]  = mk(4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0, 0, 0);
        vecs[6]  = mk(4'b0001, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 0, 0, 0);
        vecs[7]  = mk(4'b1100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0);
        vecs[8]  = mk(4'b0011, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1, 0, 1);
        vecs[9]  = mk(4'b0010, 32'h00000003, 32'h00000004, 32'h00000007, 0, 0, 0);
        vecs[10] = mk(4'b0110, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 0, 0);
        vecs[11] = mk(4'b0010, 32'h80000000, 32'h80000000, 32'h00000000, 1, 1, 0);
        vecs[12] = mk(4'b0110, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 0, 1, 0);
        vecs[13] = mk(4'b0111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 0, 0, 0);
        vecs[14] = mk(4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1, 0, 1);

        // reset state
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_ctrl = 4'b0000; op_a = '0; op_b = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_out_valid", W'(out_valid), 0);
        check("rst_result", result, 0);
        check("rst_flags", W'({zero, overflow, illegal}), 0);
        check("rst_in_ready", W'(in_ready), 1);

        // reset while a result is stalled
        in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 5; op_b = 3; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("stall_out_valid", W'(out_valid), 1);
        check("stall_result", result, 8);
        check("stall_in_ready", W'(in_ready), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_out_valid", W'(out_valid), 0);
        check("midrst_result", result, 0);
        check("midrst_in_ready", W'(in_ready), 1);

        // table vectors, issued back to back with out_ready=1 (throughput check)
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            alu_ctrl = vecs[i].ctrl; op_a = vecs[i].a; op_b = vecs[i].b;
            #1;
            check($sformatf("v%0d_in_ready", i), W'(in_ready), 1);
            tick();
            check($sformatf("v%0d_out_valid", i), W'(out_valid), 1);
            check($sformatf("v%0d_result", i), result, vecs[i].res);
            check($sformatf("v%0d_zero", i), W'(zero), W'(vecs[i].z));
            check($sformatf("v%0d_overflow", i), W'(overflow), W'(vecs[i].v));
            check($sformatf("v%0d_illegal", i), W'(illegal), W'(vecs[i].ill));
        end
        in_valid = 1'b0;
        tick();
        check("drain_out_valid", W'(out_valid), 0);

        // backpressure: 4 ADDs, out_ready pattern 1,0,0,1,1 then 1
        bp_a = '{32'd100, 32'd200, 32'd300, 32'd400};
        bp_b = '{32'd1, 32'd2, 32'd3, 32'd4};
        bp_exp = '{32'd101, 32'd202, 32'd303, 32'd404};
        pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        begin
            int sent = 0;
            int rcv = 0;
            int cyc = 0;
            logic stalled;
            logic [W-1:0] held;
            while (rcv < 4 && cyc < 20) begin
                out_ready = (cyc < 5) ? pattern[cyc] : 1'b1;
                in_valid = (sent < 4);
                alu_ctrl = 4'b0010;
                op_a = (sent < 4) ? bp_a[sent] : '0;
                op_b = (sent < 4) ? bp_b[sent] : '0;
                #1;
                check($sformatf("bp%0d_in_ready", cyc), W'(in_ready), W'(!(out_valid && !out_ready)));
                stalled = out_valid && !out_ready;
                held = result;
                if (out_valid && out_ready) begin
                    check($sformatf("bp_order%0d", rcv), result, bp_exp[rcv]);
                    rcv++;
                end
                if (in_valid && in_ready) sent++;
                tick();
                if (stalled) begin
                    check($sformatf("bp%0d_stable_valid", cyc), W'(out_valid), 1);
                    check($sformatf("bp%0d_stable_result", cyc), result, held);
                end
                cyc++;
            end
            in_valid = 1'b0;
            check("bp_count", W'(rcv), 4);
            check("bp_no_dup", W'(out_valid), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
